// File: rtl/ir_prefetch_if.sv
// Bus-side and control-side signals of the instruction prefetch buffer.
// The master is the fetch/control side; the slave is the buffer.
interface ir_prefetch_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPW   = 4
);
  logic                   ldIR;
  logic [WIDTH-1:0]       Buss;
  logic                   advance;
  logic                   flush;
  logic [WIDTH-1:0]       IR;
  logic [OPW-1:0]         opcode;
  logic                   irValid;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   overflow;

  modport master (
    output ldIR, Buss, advance, flush,
    input  IR, opcode, irValid, count, full, overflow
  );

  modport slave (
    input  ldIR, Buss, advance, flush,
    output IR, opcode, irValid, count, full, overflow
  );
endinterface

// File: rtl/ir_prefetch_buffer.sv
// Instruction prefetch queue: a DEPTH-entry circular buffer whose oldest word
// is mirrored in a registered IR, so fetch can run ahead of execute.
module ir_prefetch_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPW   = 4
) (
  input  logic           clk,
  input  logic           reset,
  ir_prefetch_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_CNT  = CW'(2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] ir_nxt;
  logic             vld_q;
  logic             full_q;
  logic             ovf_q;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    pop        = bus.advance && vld_q;
    push       = bus.ldIR && (!full_q || pop);
    drop       = bus.ldIR && full_q && !pop;
    rd_ptr_inc = rd_ptr + AW'(1);
    cnt_nxt    = cnt + CW'(push) - CW'(pop);
    ir_nxt     = ir_q;
    // The next-oldest word is already in storage when two or more are held;
    // otherwise a word arriving this cycle goes straight into IR.
    if (pop && (cnt >= TWO_CNT)) begin
      ir_nxt = mem[rd_ptr_inc];
    end else if (push && ((cnt == '0) || pop)) begin
      ir_nxt = bus.Buss;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      ir_q   <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      cnt    <= cnt_nxt;
      vld_q  <= (cnt_nxt != '0);
      full_q <= (cnt_nxt == FULL_CNT);
      ir_q   <= ir_nxt;
    end
  end

  // Storage holds data only; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= bus.Buss;
    end
  end

  assign bus.IR       = ir_q;
  assign bus.opcode   = ir_q[WIDTH-1 -: OPW];
  assign bus.irValid  = vld_q;
  assign bus.count    = cnt;
  assign bus.full     = full_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ir_prefetch_buffer.sv
// Scoreboard bench for ir_prefetch_buffer: accepted words are queued when
// driven and compared against IR as instructions are retired.
module tb_ir_prefetch_buffer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  ir_prefetch_if #(.WIDTH(16), .DEPTH(4), .OPW(4)) bif ();

  ir_prefetch_buffer #(.WIDTH(16), .DEPTH(4), .OPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic ld, input logic [15:0] d, input logic adv,
                     input logic fl, input logic rs);
    @(negedge clk);
    bif.ldIR    = ld;
    bif.Buss    = d;
    bif.advance = adv;
    bif.flush   = fl;
    reset       = rs;
    @(posedge clk);
    #1;
    @(negedge clk);
    bif.ldIR    = 1'b0;
    bif.advance = 1'b0;
    bif.flush   = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic test_reset;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bif.IR !== 16'h0) begin failures++; $display("FAIL reset_ir: got %h expected 0000", bif.IR); end
    checks++;
    if (bif.count !== 3'd0 || bif.irValid !== 1'b0) begin
      failures++; $display("FAIL reset_cnt: count=%0d irValid=%b expected 0/0", bif.count, bif.irValid);
    end
    checks++;
    if (bif.full !== 1'b0 || bif.overflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags: full=%b overflow=%b expected 0/0", bif.full, bif.overflow);
    end
  endtask

  task automatic test_single_load;
    cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bif.IR !== 16'h1234 || bif.opcode !== 4'h1) begin
      failures++; $display("FAIL load_ir: IR=%h opcode=%h expected 1234/1", bif.IR, bif.opcode);
    end
    checks++;
    if (bif.irValid !== 1'b1 || bif.count !== 3'd1) begin
      failures++; $display("FAIL load_cnt: irValid=%b count=%0d expected 1/1", bif.irValid, bif.count);
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bif.irValid !== 1'b0 || bif.count !== 3'd0 || bif.IR !== 16'h1234) begin
      failures++; $display("FAIL load_retire: irValid=%b count=%0d IR=%h expected 0/0/1234", bif.irValid, bif.count, bif.IR);
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bif.count !== 3'd0 || bif.IR !== 16'h1234) begin
      failures++; $display("FAIL empty_advance: count=%0d IR=%h expected 0/1234", bif.count, bif.IR);
    end
  endtask

  task automatic fill4;
    logic [15:0] vals [4];
    vals = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(vals[i]);
      cyc(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      exp_w = sb.pop_front();
      checks++;
      if (bif.IR !== exp_w || bif.irValid !== 1'b1) begin
        failures++; $display("FAIL %s_%0d: IR=%h irValid=%b expected %h/1", name, i, bif.IR, bif.irValid, exp_w);
      end
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (bif.irValid !== 1'b0 || bif.count !== 3'd0 || bif.IR !== exp_w) begin
      failures++; $display("FAIL %s_end: irValid=%b count=%0d IR=%h expected 0/0/%h", name, bif.irValid, bif.count, bif.IR, exp_w);
    end
  endtask

  task automatic test_fill_order;
    sb.delete();
    fill4();
    checks++;
    if (bif.full !== 1'b1 || bif.count !== 3'd4 || bif.IR !== 16'hA001) begin
      failures++; $display("FAIL fill: full=%b count=%0d IR=%h expected 1/4/a001", bif.full, bif.count, bif.IR);
    end
    drain_check("fill_order", 4);
  endtask

  task automatic test_overflow;
    sb.delete();
    fill4();
    cyc(1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bif.overflow !== 1'b1 || bif.count !== 3'd4 || bif.full !== 1'b1) begin
      failures++; $display("FAIL ovf_set: overflow=%b count=%0d full=%b expected 1/4/1", bif.overflow, bif.count, bif.full);
    end
    drain_check("ovf_drain", 4);
    checks++;
    if (bif.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", bif.overflow); end
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bif.overflow !== 1'b0) begin failures++; $display("FAIL ovf_flush: got %b expected 0", bif.overflow); end
  endtask

  task automatic test_full_push_pop;
    sb.delete();
    fill4();
    sb.push_back(16'h5555);
    void'(sb.pop_front());
    cyc(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bif.IR !== 16'hB002 || bif.count !== 3'd4 || bif.full !== 1'b1 || bif.overflow !== 1'b0) begin
      failures++; $display("FAIL full_pp: IR=%h count=%0d full=%b ovf=%b expected b002/4/1/0", bif.IR, bif.count, bif.full, bif.overflow);
    end
    drain_check("full_pp_drain", 4);
  endtask

  task automatic test_wrap;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      sb.push_back(16'(i));
      if (i > 0) void'(sb.pop_front());
      cyc(1'b1, 16'(i), (i > 0), 1'b0, 1'b0);
      checks++;
      if (bif.IR !== sb[0] || bif.count > 3'd2) begin
        failures++; $display("FAIL wrap_%0d: IR=%h count=%0d expected %h/<=2", i, bif.IR, bif.count, sb[0]);
      end
    end
    drain_check("wrap_drain", 1);
  endtask

  task automatic test_flush_precedence;
    sb.delete();
    cyc(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bif.count !== 3'd3) begin failures++; $display("FAIL pre_flush: count=%0d expected 3", bif.count); end
    cyc(1'b1, 16'h4444, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bif.count !== 3'd0 || bif.irValid !== 1'b0 || bif.IR !== 16'h1111) begin
      failures++; $display("FAIL flush: count=%0d irValid=%b IR=%h expected 0/0/1111", bif.count, bif.irValid, bif.IR);
    end
    sb.push_back(16'h6661);
    sb.push_back(16'h6662);
    cyc(1'b1, 16'h6661, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h6662, 1'b0, 1'b0, 1'b0);
    drain_check("post_flush", 2);
  endtask

  task automatic test_reset_precedence;
    sb.delete();
    cyc(1'b1, 16'h7771, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h7772, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h7773, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h4444, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bif.count !== 3'd0 || bif.irValid !== 1'b0 || bif.IR !== 16'h0) begin
      failures++; $display("FAIL reset_mid: count=%0d irValid=%b IR=%h expected 0/0/0000", bif.count, bif.irValid, bif.IR);
    end
    sb.push_back(16'h8881);
    cyc(1'b1, 16'h8881, 1'b0, 1'b0, 1'b0);
    drain_check("post_reset", 1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bif.ldIR    = 1'b0;
    bif.Buss    = 16'h0;
    bif.advance = 1'b0;
    bif.flush   = 1'b0;
    test_reset();
    test_single_load();
    test_fill_order();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_flush_precedence();
    test_reset_precedence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ir_prefetch_buffer.md
Name: ir_prefetch_buffer

Overview:
- Parametrised successor to the single-word instruction register.
- Holds up to DEPTH instruction words captured from the bus. The oldest word is presented as the current IR, so fetch can run ahead of execute.
- Sits between the memory/bus datapath and the control FSM. The control FSM retires the current instruction with `advance`.
- Also provides registered occupancy, overflow and opcode outputs.

Parameters:
- WIDTH, 16, instruction/bus word width in bits.
- DEPTH, 4, queue capacity in words including the current IR; power of two, >= 2.
- OPW, 4, opcode field width; opcode = IR[WIDTH-1 -: OPW].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ldIR  input  1  push request: capture Buss this cycle.
- Buss  input  WIDTH  bus data to capture.
- advance  input  1  retire the current IR and present the next queued word.
- flush  input  1  discard all queued words (branch/interrupt redirect).
- IR  output  WIDTH  current instruction word (registered).
- opcode  output  OPW  IR[WIDTH-1 -: OPW]; combinational slice of the IR register.
- irValid  output  1  IR holds an unretired instruction (count != 0).
- count  output  $clog2(DEPTH)+1  words held, including the current IR; range 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Precedence, highest first: reset, flush, then advance/ldIR.
- Reset, synchronous, active-high:
  - IR=0, count=0, irValid=0, full=0, overflow=0, pointers=0.
  - Reset mid-operation discards all queued words.
- Flush:
  - count=0, irValid=0, overflow=0, pointers realigned.
  - IR keeps its last value.
  - ldIR/advance in the same cycle are ignored.
- Storage: circular buffer of DEPTH entries.
  - The head entry is mirrored in the IR register.
  - Pointers wrap modulo DEPTH.
- Pop: advance && irValid.
  - advance with irValid=0 is ignored; no state change.
- Push: ldIR && (!full || pop).
  - ldIR && full && !pop drops Buss, sets overflow=1 (sticky until reset/flush), leaves the queue unchanged.
- count next value: count + push - pop.
- IR update, latency 1 cycle from the qualifying edge:
  - count==0 and push: IR <= Buss. This matches legacy single-register timing.
  - pop with count>=2: IR <= next-oldest word.
  - pop with count==1 and push: IR <= Buss.
  - pop with count==1 and no push: IR retained, irValid -> 0.
  - Otherwise IR holds.
- Simultaneous push+pop when full: both accepted, count stays DEPTH, full stays 1, no overflow.
- DEPTH-1 words remain visible after the head; ordering is strictly FIFO.
- All outputs are registered or direct slices of registers; no combinational path from inputs to outputs.

Test Plan:
- Reset then single load: reset 1 cycle; ldIR=1, Buss=16'h1234 for 1 cycle -> next cycle IR=16'h1234, irValid=1, count=1, opcode=4'h1.
- Fill and order: push 16'hA001, 16'hB002, 16'hC003, 16'hD004 (DEPTH=4) -> full=1, count=4. Then 4 advances -> IR sequence A001, B002, C003, D004 held, then irValid=0 with IR still D004, count=0.
- Overflow: with queue full, ldIR=1, Buss=16'hEEEE, no advance -> overflow=1, count=4. A later drain never yields EEEE. Overflow stays 1 until flush, then reads 0.
- Full push+pop: full with A001..D004; ldIR=1, Buss=16'h5555, advance=1 -> IR=B002, count=4, overflow=0. Draining yields B002, C003, D004, 5555.
- Wrap-around: 10 cycles of alternating push/pop, values 16'h0000..16'h0009 -> every value appears on IR exactly once in order; count never exceeds 2.
- Flush/reset precedence: count=3; flush=1 with ldIR=1 and advance=1 -> count=0, irValid=0, IR unchanged. Repeat with reset=1 -> IR=0.
